harness_cmd_engine: RTL and testbench

Synthesizable, parametrised successor to the simulation command harness. Consumes a byte-wide command stream and drives a DUT's packed input vector, reset and clock enable. Captures the DUT's packed output vector and returns it as a byte-wide response stream, so the same host protocol works on FPGA behind a UART/FIFO bridge. Adds over the simulation harness: valid/ready flow control, multi-cycle step counts, atomic input commit, sticky error reporting.

---
 rtl/harness_cmd_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_harness_cmd_engine.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/harness_cmd_engine.sv
// Byte-stream command engine driving a DUT's packed inputs, reset and clock enable.
// Optional macro HARNESS_ACK_EN: acknowledge non-read commands with a 0x2E response byte.
module harness_cmd_engine #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 32,
  parameter int STEP_BYTES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           cmd_data,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic [7:0]           rsp_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IN_WIDTH-1:0]  dut_in,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 dut_rst,
  output logic                 dut_ce,
  output logic                 done,
  output logic                 err
);

  localparam int IN_BYTES  = (IN_WIDTH + 7) / 8;
  localparam int OUT_BYTES = (OUT_WIDTH + 7) / 8;
  localparam int SW        = STEP_BYTES * 8;
  localparam logic [15:0] IN_LAST   = 16'(IN_BYTES - 1);
  localparam logic [15:0] STEP_LAST = 16'(STEP_BYTES - 1);
  localparam logic [15:0] OUT_LAST  = 16'(OUT_BYTES - 1);

`ifdef HARNESS_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD_ARG, STEP_ARG, STEP, RESP, HALT} state_t;

  state_t                   state_r;
  logic [15:0]              arg_idx_r;
  logic [IN_WIDTH-1:0]      shadow_r;
  logic [IN_WIDTH-1:0]      dut_in_r;
  logic [SW-1:0]            count_r;
  logic [SW-1:0]            step_left_r;
  logic [OUT_BYTES*8-1:0]   rsp_buf_r;
  logic [15:0]              rsp_left_r;
  logic [7:0]               rsp_data_r;
  logic                     rsp_valid_r;
  logic                     halt_after_r;
  logic                     dut_rst_r;
  logic                     dut_ce_r;
  logic                     done_r;
  logic                     err_r;

  logic                     accept_s;
  logic [OUT_BYTES*8-1:0]   snap_s;
  logic [IN_WIDTH+7:0]      shadow_cat_s;
  logic [IN_WIDTH-1:0]      shadow_next_s;
  logic [SW+7:0]            step_cat_s;
  logic [SW-1:0]            step_next_s;
  logic                     unused_bits_s;

  assign cmd_ready = (state_r == IDLE) || (state_r == LOAD_ARG) || (state_r == STEP_ARG);
  assign accept_s  = cmd_valid && cmd_ready;

  // Load shifts bytes in MSB-first; step count shifts bytes in LSB-first from the top.
  assign shadow_cat_s  = {shadow_r, cmd_data};
  assign shadow_next_s = shadow_cat_s[IN_WIDTH-1:0];
  assign step_cat_s    = {cmd_data, count_r};
  assign step_next_s   = step_cat_s[SW+7:8];
  assign unused_bits_s = ^{shadow_cat_s[IN_WIDTH+7:IN_WIDTH], step_cat_s[7:0]};

  // Zero-pad the DUT output snapshot up to a whole number of bytes.
  always_comb begin
    snap_s = '0;
    snap_s[OUT_WIDTH-1:0] = dut_out;
  end

  // Command FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      arg_idx_r    <= 16'd0;
      shadow_r     <= '0;
      dut_in_r     <= '0;
      count_r      <= '0;
      step_left_r  <= '0;
      rsp_buf_r    <= '0;
      rsp_left_r   <= 16'd0;
      rsp_data_r   <= 8'h00;
      rsp_valid_r  <= 1'b0;
      halt_after_r <= 1'b0;
      dut_rst_r    <= 1'b1;
      dut_ce_r     <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            arg_idx_r <= 16'd0;
            case (cmd_data)
              8'h68: begin
                rsp_data_r   <= snap_s[7:0];
                rsp_buf_r    <= snap_s >> 8;
                rsp_left_r   <= OUT_LAST;
                rsp_valid_r  <= 1'b1;
                halt_after_r <= 1'b0;
                state_r      <= RESP;
              end
              8'h69: begin
                done_r  <= 1'b1;
                state_r <= HALT;
              end
              8'h6A, 8'h6B: begin
                dut_rst_r <= (cmd_data == 8'h6A);
                if (ACK_EN) begin
                  rsp_data_r  <= 8'h2E;
                  rsp_left_r  <= 16'd0;
                  rsp_valid_r <= 1'b1;
                  state_r     <= RESP;
                end else begin
                  state_r <= IDLE;
                end
              end
              8'h6C:   state_r <= STEP_ARG;
              8'h6D:   state_r <= LOAD_ARG;
              default: begin
                err_r  <= 1'b1;
                done_r <= 1'b1;
                if (ACK_EN) begin
                  rsp_data_r   <= 8'h21;
                  rsp_left_r   <= 16'd0;
                  rsp_valid_r  <= 1'b1;
                  halt_after_r <= 1'b1;
                  state_r      <= RESP;
                end else begin
                  state_r <= HALT;
                end
              end
            endcase
          end
        end
        LOAD_ARG: begin
          if (accept_s) begin
            shadow_r <= shadow_next_s;
            if (arg_idx_r == IN_LAST) begin
              dut_in_r <= shadow_next_s;
              if (ACK_EN) begin
                rsp_data_r  <= 8'h2E;
                rsp_left_r  <= 16'd0;
                rsp_valid_r <= 1'b1;
                state_r     <= RESP;
              end else begin
                state_r <= IDLE;
              end
            end else begin
              arg_idx_r <= arg_idx_r + 16'd1;
            end
          end
        end
        STEP_ARG: begin
          if (accept_s) begin
            count_r <= step_next_s;
            if (arg_idx_r == STEP_LAST) begin
              if (step_next_s != '0) begin
                dut_ce_r    <= 1'b1;
                step_left_r <= step_next_s;
                state_r     <= STEP;
              end else if (ACK_EN) begin
                rsp_data_r  <= 8'h2E;
                rsp_left_r  <= 16'd0;
                rsp_valid_r <= 1'b1;
                state_r     <= RESP;
              end else begin
                state_r <= IDLE;
              end
            end else begin
              arg_idx_r <= arg_idx_r + 16'd1;
            end
          end
        end
        STEP: begin
          if (step_left_r == SW'(1)) begin
            dut_ce_r <= 1'b0;
            if (ACK_EN) begin
              rsp_data_r  <= 8'h2E;
              rsp_left_r  <= 16'd0;
              rsp_valid_r <= 1'b1;
              state_r     <= RESP;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            step_left_r <= step_left_r - SW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            if (rsp_left_r == 16'd0) begin
              rsp_valid_r <= 1'b0;
              state_r     <= halt_after_r ? HALT : IDLE;
            end else begin
              rsp_data_r <= rsp_buf_r[7:0];
              rsp_buf_r  <= rsp_buf_r >> 8;
              rsp_left_r <= rsp_left_r - 16'd1;
            end
          end
        end
        HALT:    state_r <= HALT;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign rsp_data  = rsp_data_r;
  assign rsp_valid = rsp_valid_r;
  assign dut_in    = dut_in_r;
  assign dut_rst   = dut_rst_r;
  assign dut_ce    = dut_ce_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_harness_cmd_engine.sv
// Self-checking bench for harness_cmd_engine: vector tables, directed corner cases, randomized model run.
module tb_harness_cmd_engine;

`ifdef HARNESS_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        man_ready = 1'b1;
  logic        rnd_ready = 1'b1;
  logic        bp_rand = 1'b0;
  logic [31:0] dut_in;
  logic [31:0] dut_out = 32'h0;
  logic        dut_rst, dut_ce, done, err;

  logic [7:0]  c12_data = 8'h00;
  logic        c12_valid = 1'b0;
  logic        c12_ready;
  logic [7:0]  r12_data;
  logic        r12_valid;
  logic        r12_ready = 1'b1;
  logic [11:0] in12;
  logic [11:0] out12 = 12'h0;
  logic        rst12, ce12, done12, err12;

  int passed = 0;
  int total  = 0;
  logic [7:0] got_q[$];
  int ce_count = 0;

  harness_cmd_engine dut (
    .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .dut_in(dut_in),
    .dut_out(dut_out), .dut_rst(dut_rst), .dut_ce(dut_ce), .done(done), .err(err)
  );

  harness_cmd_engine #(.IN_WIDTH(12), .OUT_WIDTH(12), .STEP_BYTES(2)) dut12 (
    .clk(clk), .rst(rst), .cmd_data(c12_data), .cmd_valid(c12_valid), .cmd_ready(c12_ready),
    .rsp_data(r12_data), .rsp_valid(r12_valid), .rsp_ready(r12_ready), .dut_in(in12),
    .dut_out(out12), .dut_rst(rst12), .dut_ce(ce12), .done(done12), .err(err12)
  );

  always #5 clk = ~clk;

  assign rsp_ready = bp_rand ? rnd_ready : man_ready;

  always @(posedge clk) begin
    #1 rnd_ready <= ($urandom_range(0, 3) != 0);
  end

  // Mid-cycle observation: a byte present with ready here transfers on the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) got_q.push_back(rsp_data);
      if (dut_ce) ce_count <= ce_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (cmd_ready) tick();
    else chk("send_ready_timeout", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(cmd_ready && !rsp_valid && !dut_ce) && n < 500) begin
      tick();
      n++;
    end
    if (!(cmd_ready && !rsp_valid && !dut_ce)) chk("idle_timeout", {63'd0, cmd_ready}, 64'd1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_dut_rst"}, {63'd0, dut_rst}, 64'd1);
    chk({tag, "_dut_in"}, {32'd0, dut_in}, 64'd0);
    chk({tag, "_dut_ce"}, {63'd0, dut_ce}, 64'd0);
    chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    chk({tag, "_rsp_data"}, {56'd0, rsp_data}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
  endtask

  typedef struct { logic [31:0] value; logic [31:0] bytes_out; } rd_vec_t;
  typedef struct { logic [31:0] bytes_in; logic [31:0] expect_in; } ld_vec_t;

  initial begin
    rd_vec_t rd_tab[5];
    ld_vec_t ld_tab[3];
    logic [7:0] exp_q[$];
    int base, base_ce, op, nstep, exp_ce;
    logic [31:0] v, w, exp_in;
    logic exp_rst;

    // Read vectors: bytes_out lists emitted bytes, first in the top byte.
    rd_tab[0] = '{32'hA1B2C3D4, 32'hD4C3B2A1};
    rd_tab[1] = '{32'h00000000, 32'h00000000};
    rd_tab[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    rd_tab[3] = '{32'h12345678, 32'h78563412};
    rd_tab[4] = '{32'h80000001, 32'h01000080};
    // Load vectors: bytes_in lists bytes sent, first in the top byte.
    ld_tab[0] = '{32'hDEADBEEF, 32'hDEADBEEF};
    ld_tab[1] = '{32'h00000000, 32'h00000000};
    ld_tab[2] = '{32'h80000001, 32'h80000001};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk_reset_values("reset");
    rst = 1'b0;
    tick();
    chk("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

    // Release DUT reset: falls one cycle after acceptance
    cmd_data = 8'h6B;
    cmd_valid = 1'b1;
    chk("rst_in_accept_cycle", {63'd0, dut_rst}, 64'd1);
    tick();
    cmd_valid = 1'b0;
    chk("rst_after_6b", {63'd0, dut_rst}, 64'd0);
    wait_idle();

    // Read with backpressure mid-response
    base = got_q.size();
    man_ready = 1'b0;
    dut_out = 32'hA1B2C3D4;
    send_byte(8'h68);
    dut_out = 32'h0;
    chk("rd_first_valid", {63'd0, rsp_valid}, 64'd1);
    chk("rd_first_byte", {56'd0, rsp_data}, 64'hD4);
    chk("rd_busy_not_ready", {63'd0, cmd_ready}, 64'd0);
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rd_hold_byte", {56'd0, rsp_data}, 64'hC3);
      chk("rd_hold_valid", {63'd0, rsp_valid}, 64'd1);
      tick();
    end
    man_ready = 1'b1;
    wait_idle();
    chk("rd_hold_count", 64'(got_q.size() - base), 64'd4);
    if (got_q.size() >= base + 4) begin
      chk("rd_hold_b0", {56'd0, got_q[base]}, 64'hD4);
      chk("rd_hold_b1", {56'd0, got_q[base+1]}, 64'hC3);
      chk("rd_hold_b2", {56'd0, got_q[base+2]}, 64'hB2);
      chk("rd_hold_b3", {56'd0, got_q[base+3]}, 64'hA1);
    end

    // Table-driven reads
    for (int t = 0; t < 5; t++) begin
      base = got_q.size();
      dut_out = rd_tab[t].value;
      send_byte(8'h68);
      dut_out = ~rd_tab[t].value;
      wait_idle();
      chk("rd_tab_count", 64'(got_q.size() - base), 64'd4);
      if (got_q.size() >= base + 4) begin
        for (int i = 0; i < 4; i++)
          chk("rd_tab_byte", {56'd0, got_q[base+i]}, {56'd0, rd_tab[t].bytes_out[31-8*i -: 8]});
      end
    end

    // Atomic load: dut_in unchanged until the cycle after the last byte
    send_byte(8'h6D);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("ld_mid1", {32'd0, dut_in}, 64'd0);
    send_byte(8'h56);
    chk("ld_mid_last_cycle", {32'd0, dut_in}, 64'd0);
    send_byte(8'h78);
    chk("ld_commit", {32'd0, dut_in}, 64'h12345678);
    wait_idle();

    // Table-driven loads
    for (int t = 0; t < 3; t++) begin
      send_byte(8'h6D);
      for (int i = 0; i < 4; i++) send_byte(ld_tab[t].bytes_in[31-8*i -: 8]);
      wait_idle();
      chk("ld_tab", {32'd0, dut_in}, {32'd0, ld_tab[t].expect_in});
    end

    // Step 5: exactly five consecutive ce cycles with cmd_ready low
    base_ce = ce_count;
    send_byte(8'h6C);
    send_byte(8'h05);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("step5_ce", {63'd0, dut_ce}, 64'd1);
      chk("step5_busy", {63'd0, cmd_ready}, 64'd0);
      tick();
    end
    chk("step5_ce_end", {63'd0, dut_ce}, 64'd0);
    chk("step5_ready_end", {63'd0, cmd_ready}, {63'd0, !ACK});
    wait_idle();
    chk("step5_count", 64'(ce_count - base_ce), 64'd5);

    // Step 0: no pulse
    base_ce = ce_count;
    send_byte(8'h6C);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("step0_ce", {63'd0, dut_ce}, 64'd0);
    wait_idle();
    chk("step0_count", 64'(ce_count - base_ce), 64'd0);

    // Reset in the middle of a long step
    send_byte(8'h6C);
    send_byte(8'h64);
    send_byte(8'h00);
    repeat (9) tick();
    chk("step100_ce_before_rst", {63'd0, dut_ce}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("step_rst_ce", {63'd0, dut_ce}, 64'd0);
    chk("step_rst_dut_rst", {63'd0, dut_rst}, 64'd1);
    chk("step_rst_idle", {63'd0, cmd_ready}, 64'd1);

    // Narrow instance: 12-bit read padding and load truncation
    out12 = 12'hABC;
    c12_data = 8'h68;
    c12_valid = 1'b1;
    tick();
    c12_valid = 1'b0;
    chk("w12_rd_b0", {56'd0, r12_data}, 64'hBC);
    chk("w12_rd_v0", {63'd0, r12_valid}, 64'd1);
    tick();
    chk("w12_rd_b1", {56'd0, r12_data}, 64'h0A);
    tick();
    chk("w12_rd_done", {63'd0, r12_valid}, 64'd0);
    c12_valid = 1'b1;
    c12_data = 8'h6D;
    tick();
    c12_data = 8'hFF;
    tick();
    c12_data = 8'hED;
    tick();
    c12_valid = 1'b0;
    chk("w12_load", {52'd0, in12}, 64'hFED);

    // Randomized run against a transaction-level model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    exp_rst = 1'b1;
    exp_in  = 32'h0;
    exp_ce  = 0;
    bp_rand = 1'b1;
    base    = got_q.size();
    base_ce = ce_count;
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          v = $urandom;
          for (int i = 0; i < 4; i++) exp_q.push_back(8'((v >> (8 * i)) & 32'hFF));
          dut_out = v;
          send_byte(8'h68);
          dut_out = $urandom;
        end
        1: begin
          exp_rst = 1'b1;
          if (ACK) exp_q.push_back(8'h2E);
          send_byte(8'h6A);
        end
        2: begin
          exp_rst = 1'b0;
          if (ACK) exp_q.push_back(8'h2E);
          send_byte(8'h6B);
        end
        3: begin
          nstep = $urandom_range(0, 6);
          exp_ce += nstep;
          if (ACK) exp_q.push_back(8'h2E);
          send_byte(8'h6C);
          send_byte(8'(nstep));
          send_byte(8'h00);
        end
        default: begin
          w = $urandom;
          exp_in = w;
          if (ACK) exp_q.push_back(8'h2E);
          send_byte(8'h6D);
          for (int i = 0; i < 4; i++) send_byte(8'((w >> (24 - 8 * i)) & 32'hFF));
        end
      endcase
      wait_idle();
      chk("rnd_dut_rst", {63'd0, dut_rst}, {63'd0, exp_rst});
      chk("rnd_dut_in", {32'd0, dut_in}, {32'd0, exp_in});
    end
    bp_rand = 1'b0;
    chk("rnd_ce_total", 64'(ce_count - base_ce), 64'(exp_ce));
    chk("rnd_rsp_count", 64'(got_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) chk("rnd_rsp_byte", {56'd0, got_q[base+i]}, {56'd0, exp_q[i]});
    end

    // Reset-control commands produce a response only when acknowledgements are built in
    send_byte(8'h6B);
    wait_idle();
    base = got_q.size();
    send_byte(8'h6A);
    wait_idle();
    chk("ack_6a_dut_rst", {63'd0, dut_rst}, 64'd1);
    chk("ack_6a_count", 64'(got_q.size() - base), {63'd0, ACK});
    if (got_q.size() > base) chk("ack_6a_byte", {56'd0, got_q[base]}, 64'h2E);

    // Unknown command: sticky error and halt until reset
    send_byte(8'h41);
    chk("unk_err", {63'd0, err}, 64'd1);
    chk("unk_done", {63'd0, done}, 64'd1);
    chk("unk_not_ready", {63'd0, cmd_ready}, 64'd0);
    repeat (5) tick();
    chk("unk_still_halted", {63'd0, cmd_ready}, 64'd0);
    chk("unk_err_sticky", {63'd0, err}, 64'd1);
    rst = 1'b1;
    tick();
    chk_reset_values("unk_rst");
    rst = 1'b0;
    tick();

    // Quit: done without error
    send_byte(8'h69);
    chk("quit_done", {63'd0, done}, 64'd1);
    chk("quit_no_err", {63'd0, err}, 64'd0);
    chk("quit_halt", {63'd0, cmd_ready}, 64'd0);
    rst = 1'b1;
    tick();
    chk("quit_rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
